// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle; the master modport drives the request side.
interface wshb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_ms;
  logic [DW-1:0]   dat_sm;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  dat_sm, ack, err, rty);
  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output dat_sm, ack, err, rty);
endinterface

// File: rtl/wb_arbiter2_rr_arb2.sv
// Two-way round-robin decision with the last-served pointer register.
module rr_arb2
  import wb_arb_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       winner
);

  logic last_r;

  // Last-served pointer; reset value makes FIRST_PRIO win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= ~FIRST_PRIO;
    end else if (upd) begin
      last_r <= upd_idx;
    end else begin
      last_r <= last_r;
    end
  end

  // Winner selection: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    winner = ~last_r;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_r;
      default: winner = ~last_r;
    endcase
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter granting whole cyc-bounded cycles
// with round-robin fairness and per-master ack counters.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int FIRST_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wshb_if.slave                wb_m0,
  wshb_if.slave                wb_m1,
  wshb_if.master               wb_s,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] ack_cnt0,
  output logic [CNT_WIDTH-1:0] ack_cnt1
);

  arb_state_t state_r;
  arb_state_t state_nxt;
  logic       winner_s;
  logic       upd_s;
  logic       upd_idx_s;
  logic       ack0_s, err0_s, rty0_s;
  logic       ack1_s, err1_s, rty1_s;

  rr_arb2 #(.FIRST_PRIO(FIRST_PRIO == 1)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({wb_m1.cyc, wb_m0.cyc}),
    .upd     (upd_s),
    .upd_idx (upd_idx_s),
    .winner  (winner_s)
  );

  // Release is seen the edge the owner's cyc is low; that edge records it as last served.
  always_comb begin
    upd_s     = 1'b0;
    upd_idx_s = 1'b0;
    case (state_r)
      GNT0: begin
        upd_s     = ~wb_m0.cyc;
        upd_idx_s = 1'b0;
      end
      GNT1: begin
        upd_s     = ~wb_m1.cyc;
        upd_idx_s = 1'b1;
      end
      default: begin
        upd_s     = 1'b0;
        upd_idx_s = 1'b0;
      end
    endcase
  end

  // Next-state: hold while the owner keeps cyc, hand over directly if the other waits.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (wb_m0.cyc || wb_m1.cyc) begin
          state_nxt = winner_s ? GNT1 : GNT0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT0: begin
        if (wb_m0.cyc) begin
          state_nxt = GNT0;
        end else begin
          state_nxt = wb_m1.cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (wb_m1.cyc) begin
          state_nxt = GNT1;
        end else begin
          state_nxt = wb_m0.cyc ? GNT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  assign grant = state_r;

  // Bus routing from the registered grant; everything is quiet when idle.
  always_comb begin
    wb_s.cyc    = 1'b0;
    wb_s.stb    = 1'b0;
    wb_s.we     = 1'b0;
    wb_s.adr    = '0;
    wb_s.dat_ms = '0;
    wb_s.sel    = '0;
    wb_s.cti    = CTI_CLASSIC;
    wb_s.bte    = 2'b00;
    ack0_s = 1'b0; err0_s = 1'b0; rty0_s = 1'b0;
    ack1_s = 1'b0; err1_s = 1'b0; rty1_s = 1'b0;
    case (state_r)
      GNT0: begin
        wb_s.cyc    = wb_m0.cyc;
        wb_s.stb    = wb_m0.cyc & wb_m0.stb;
        wb_s.we     = wb_m0.we;
        wb_s.adr    = wb_m0.adr;
        wb_s.dat_ms = wb_m0.dat_ms;
        wb_s.sel    = wb_m0.sel;
        wb_s.cti    = wb_m0.cti;
        wb_s.bte    = wb_m0.bte;
        ack0_s = wb_s.ack; err0_s = wb_s.err; rty0_s = wb_s.rty;
      end
      GNT1: begin
        wb_s.cyc    = wb_m1.cyc;
        wb_s.stb    = wb_m1.cyc & wb_m1.stb;
        wb_s.we     = wb_m1.we;
        wb_s.adr    = wb_m1.adr;
        wb_s.dat_ms = wb_m1.dat_ms;
        wb_s.sel    = wb_m1.sel;
        wb_s.cti    = wb_m1.cti;
        wb_s.bte    = wb_m1.bte;
        ack1_s = wb_s.ack; err1_s = wb_s.err; rty1_s = wb_s.rty;
      end
      default: begin
        wb_s.cyc = 1'b0;
      end
    endcase
  end

  assign wb_m0.ack    = ack0_s;
  assign wb_m0.err    = err0_s;
  assign wb_m0.rty    = rty0_s;
  assign wb_m0.dat_sm = wb_s.dat_sm;
  assign wb_m1.ack    = ack1_s;
  assign wb_m1.err    = err1_s;
  assign wb_m1.rty    = rty1_s;
  assign wb_m1.dat_sm = wb_s.dat_sm;

  // Delivered-ack counters, wrapping modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt0 <= '0;
      ack_cnt1 <= '0;
    end else begin
      if (ack0_s) ack_cnt0 <= ack_cnt0 + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else        ack_cnt0 <= ack_cnt0;
      if (ack1_s) ack_cnt1 <= ack_cnt1 + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else        ack_cnt1 <= ack_cnt1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: two procedural masters and a small RAM slave.
module tb_wb_arbiter2;
  import wb_arb_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();

  logic [1:0]    grant;
  logic [CW-1:0] cnt0, cnt1;

  wb_arbiter2 #(.CNT_WIDTH(CW), .FIRST_PRIO(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_m0    (m0_if),
    .wb_m1    (m1_if),
    .wb_s     (s_if),
    .grant    (grant),
    .ack_cnt0 (cnt0),
    .ack_cnt1 (cnt1)
  );

  // Slave: one wait state per beat, read-before-write RAM.
  logic [31:0] mem [0:255];
  assign s_if.err = 1'b0;
  assign s_if.rty = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_if.ack    <= 1'b0;
      s_if.dat_sm <= 32'h0;
    end else if (s_if.cyc && s_if.stb && !s_if.ack) begin
      s_if.ack    <= 1'b1;
      s_if.dat_sm <= mem[s_if.adr[7:0]];
      if (s_if.we) mem[s_if.adr[7:0]] <= s_if.dat_ms;
    end else begin
      s_if.ack <= 1'b0;
    end
  end

  // Grant-change history for ordering checks.
  logic [1:0] hist [$];
  logic [1:0] prev_g;
  always @(negedge clk) begin
    if (grant != prev_g) hist.push_back(grant);
    prev_g <= grant;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] rd0, rd1;
  logic        m1_done;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          beats;
    logic        burst;
    logic [31:0] exp_rdat;
    logic [CW-1:0] exp_c0;
    logic [CW-1:0] exp_c1;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(input int idx, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    if (idx == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.adr = adr;
      m0_if.dat_ms = dat; m0_if.sel = 4'hF; m0_if.cti = cti; m0_if.bte = 2'b00;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.adr = adr;
      m1_if.dat_ms = dat; m1_if.sel = 4'hF; m1_if.cti = cti; m1_if.bte = 2'b00;
    end
  endtask

  function automatic logic get_ack(input int idx);
    return (idx == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  function automatic logic [31:0] get_dat(input int idx);
    return (idx == 0) ? m0_if.dat_sm : m1_if.dat_sm;
  endfunction

  // One Wishbone cycle; cyc drops in the cycle of the final ack.
  task automatic wb_xfer(input int idx, input logic we, input logic [31:0] adr,
                         input logic [31:0] wdat, input int beats, input logic burst,
                         output logic [31:0] rdat);
    int waited;
    logic [2:0] cti;
    rdat = 32'h0;
    @(posedge clk); #1;
    for (int b = 0; b < beats; b++) begin
      cti = !burst ? CTI_CLASSIC : ((b == beats - 1) ? CTI_END : CTI_INCR);
      set_bus(idx, 1'b1, 1'b1, we, adr + 32'(b), wdat + 32'(b), cti);
      waited = 0;
      do begin
        @(posedge clk); #1;
        waited++;
      end while (!get_ack(idx) && waited < 100);
      chk($sformatf("xfer_ack_m%0d", idx), {31'b0, get_ack(idx)}, 32'h1);
      rdat = get_dat(idx);
      if (!get_ack(idx)) break;
    end
    set_bus(idx, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
  endtask

  task automatic do_reset();
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack, waited;
    vecs[0] = '{1, 1'b1, 32'h20, 32'h12345678, 1, 1'b0, 32'h0,        4'd1,  4'd1};
    vecs[1] = '{0, 1'b0, 32'h20, 32'h0,        1, 1'b0, 32'h12345678, 4'd2,  4'd1};
    vecs[2] = '{1, 1'b0, 32'h10, 32'h0,        1, 1'b0, 32'hDEADBEEF, 4'd2,  4'd2};
    vecs[3] = '{0, 1'b1, 32'h40, 32'hA0,       8, 1'b1, 32'h0,        4'd10, 4'd2};
    vecs[4] = '{1, 1'b0, 32'h40, 32'h0,        8, 1'b1, 32'hA7,       4'd10, 4'd10};
    vecs[5] = '{0, 1'b0, 32'h43, 32'h0,        1, 1'b0, 32'hA3,       4'd11, 4'd10};

    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    chk("rst_grant", grant, 32'h0);
    chk("rst_cnt0", cnt0, 32'h0);
    chk("rst_cnt1", cnt1, 32'h0);
    chk("rst_s_cyc", s_if.cyc, 32'h0);
    chk("rst_s_stb", s_if.stb, 32'h0);
    chk("rst_s_adr", s_if.adr, 32'h0);
    chk("rst_m0_ack", m0_if.ack, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single write from m0: one arbitration cycle, then strobe, then ack.
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, CTI_CLASSIC);
    chk("w1_grant_req_cycle", grant, 32'h0);
    @(posedge clk); #1;
    chk("w1_grant", grant, 32'h1);
    chk("w1_s_stb", s_if.stb, 32'h1);
    chk("w1_s_we", s_if.we, 32'h1);
    chk("w1_s_adr", s_if.adr, 32'h10);
    chk("w1_s_dat", s_if.dat_ms, 32'hDEADBEEF);
    chk("w1_s_sel", s_if.sel, 32'hF);
    @(posedge clk); #1;
    chk("w1_m0_ack", m0_if.ack, 32'h1);
    chk("w1_m1_ack", m1_if.ack, 32'h0);
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    @(posedge clk); #1;
    chk("w1_cnt0", cnt0, 32'h1);
    chk("w1_cnt1", cnt1, 32'h0);
    chk("w1_grant_idle", grant, 32'h0);

    // stb without cyc is ignored.
    set_bus(1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
    repeat (3) @(posedge clk);
    #1;
    chk("stb_only_grant", grant, 32'h0);
    chk("stb_only_s_stb", s_if.stb, 32'h0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);

    // Transaction table.
    for (int v = 0; v < 6; v++) begin
      wb_xfer(vecs[v].idx, vecs[v].we, vecs[v].adr, vecs[v].wdat, vecs[v].beats,
              vecs[v].burst, rd0);
      if (!vecs[v].we) chk($sformatf("vec%0d_rdat", v), rd0, vecs[v].exp_rdat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_cnt0", v), cnt0, vecs[v].exp_c0);
      chk($sformatf("vec%0d_cnt1", v), cnt1, vecs[v].exp_c1);
    end

    // Simultaneous request after reset: m0 first, direct handoff to m1.
    do_reset();
    hist.delete();
    fork
      wb_xfer(0, 1'b0, 32'h10, 32'h0, 1, 1'b0, rd0);
      wb_xfer(1, 1'b0, 32'h10, 32'h0, 1, 1'b0, rd1);
    join
    repeat (2) @(posedge clk);
    #1;
    chk("sim_rd0", rd0, 32'hDEADBEEF);
    chk("sim_rd1", rd1, 32'hDEADBEEF);
    chk("sim_cnt0", cnt0, 32'h1);
    chk("sim_cnt1", cnt1, 32'h1);
    chk("sim_hist_len", hist.size(), 32'd3);
    if (hist.size() == 3) begin
      chk("sim_hist0", hist[0], 32'h1);
      chk("sim_hist1", hist[1], 32'h2);
      chk("sim_hist2", hist[2], 32'h0);
    end

    // Burst lock: m0 arriving mid-burst waits for m1 to release.
    do_reset();
    hist.delete();
    m1_done = 1'b0;
    fork
      begin
        wb_xfer(1, 1'b0, 32'h40, 32'h0, 8, 1'b1, rd1);
        m1_done = 1'b1;
      end
      begin
        repeat (6) @(posedge clk);
        wb_xfer(0, 1'b0, 32'h10, 32'h0, 1, 1'b0, rd0);
        chk("lock_m0_after_m1", m1_done, 32'h1);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("lock_rd1", rd1, 32'hA7);
    chk("lock_rd0", rd0, 32'hDEADBEEF);
    chk("lock_cnt1", cnt1, 32'h8);
    chk("lock_cnt0", cnt0, 32'h1);
    chk("lock_hist_len", hist.size(), 32'd3);
    if (hist.size() == 3) begin
      chk("lock_hist0", hist[0], 32'h2);
      chk("lock_hist1", hist[1], 32'h1);
    end

    // Round-robin: four back-to-back cycles per master alternate.
    do_reset();
    hist.delete();
    fork
      for (int i = 0; i < 4; i++) wb_xfer(0, 1'b1, 32'h60 + 32'(i), 32'(i), 1, 1'b0, rd0);
      for (int j = 0; j < 4; j++) wb_xfer(1, 1'b1, 32'h70 + 32'(j), 32'(j), 1, 1'b0, rd1);
    join
    repeat (2) @(posedge clk);
    #1;
    chk("rr_cnt0", cnt0, 32'h4);
    chk("rr_cnt1", cnt1, 32'h4);
    chk("rr_hist_len", hist.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < hist.size())
        chk($sformatf("rr_hist%0d", i), hist[i],
            (i == 8) ? 32'h0 : ((i % 2 == 0) ? 32'h1 : 32'h2));
    end

    // Async reset at burst beat 3, between clock edges.
    do_reset();
    @(posedge clk); #1;
    set_bus(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, CTI_INCR);
    nack = 0;
    waited = 0;
    while (nack < 2 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
      if (m1_if.ack) begin
        nack++;
        set_bus(1, 1'b1, 1'b1, 1'b0, 32'h40 + 32'(nack), 32'h0, CTI_INCR);
      end
    end
    chk("arst_two_beats", nack, 32'd2);
    chk("arst_cnt1_pre", cnt1, 32'h1);
    @(posedge clk); #3;
    chk("arst_grant_pre", grant, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 32'h0);
    chk("arst_s_cyc", s_if.cyc, 32'h0);
    chk("arst_cnt1", cnt1, 32'h0);
    chk("arst_m1_ack", m1_if.ack, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_ack", m1_if.ack, 32'h0);
    chk("arst_hold_grant", grant, 32'h0);
    set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    @(negedge clk); rst_n = 1'b1;
    wb_xfer(1, 1'b0, 32'h10, 32'h0, 1, 1'b0, rd1);
    @(posedge clk); #1;
    chk("arst_after_rd", rd1, 32'hDEADBEEF);
    chk("arst_after_cnt1", cnt1, 32'h1);

    // Counter wrap at 4 bits: 16 acks -> 0, 17 acks -> 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wb_xfer(0, 1'b1, 32'h80 + 32'(i), 32'(i), 1, 1'b0, rd0);
      if (i == 15) begin
        @(posedge clk); #1;
        chk("wrap_cnt0_16", cnt0, 32'h0);
      end
    end
    @(posedge clk); #1;
    chk("wrap_cnt0_17", cnt0, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter that shares a single wb_bram (or any wshb_if slave) between two requesters, e.g. a video read path and a CPU/pattern writer.
- Grants whole Wishbone cycles (cyc-bounded), including incrementing bursts (cti 001/010 terminated by 111), with round-robin fairness.
- Keeps per-master acknowledged-transfer counters for debug.
- Sits between the masters' wshb_if instances and the memory's wshb_if.slave port.

Parameters:
- CNT_WIDTH, 16, width of each per-master ack counter.
- FIRST_PRIO, 0, master that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  system clock; all masters and the slave share it.
- rst_n  input  1  asynchronous active-low reset.
- wb_m0  interface  wshb_if.slave  requester 0.
- wb_m1  interface  wshb_if.slave  requester 1.
- wb_s  interface  wshb_if.master  towards the shared slave.
- grant  output  2  one-hot current grant; 00 = idle.
- ack_cnt0  output  CNT_WIDTH  acks delivered to master 0, wraps.
- ack_cnt1  output  CNT_WIDTH  acks delivered to master 1, wraps.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; grant=00; last-served pointer set so FIRST_PRIO wins the first tie.
  - ack_cnt0 and ack_cnt1 = 0; wb_s.cyc/stb/we = 0; adr/dat_ms/sel/cti/bte = 0.
  - ack, err and rty to both masters = 0.
- States: IDLE, GNT0, GNT1 (registered, 2-bit encoding in package).
- IDLE:
  - Only m0.cyc high -> GNT0; only m1.cyc high -> GNT1.
  - Both high -> the master not served last.
  - Neither -> stay IDLE.
  - Arbitration costs exactly 1 cycle: the first slave strobe appears the cycle after the IDLE decision.
- GNTx, while mx.cyc is high:
  - Stay in GNTx regardless of the other master; no preemption mid-cycle or mid-burst.
- GNTx, when mx.cyc is low:
  - Update the last-served pointer to x.
  - If the other master's cyc is high, go directly to GNTother (no IDLE bubble); else go to IDLE.
  - During this handoff edge, wb_s.cyc/stb are driven from the newly granted master only from the next cycle. Slave sees cyc=0 for at least 1 cycle between owners.
- Routing (combinational from the registered state):
  - In GNTx: wb_s.{cyc,stb,we,adr,dat_ms,sel,cti,bte} = mx.*; mx.ack = wb_s.ack; mx.err/rty = wb_s.err/rty.
  - Non-granted master: ack/err/rty = 0, so its cycle simply waits (wait states).
  - IDLE: wb_s.cyc = wb_s.stb = 0.
  - wb_s.dat_sm is fanned out to both masters' dat_sm unchanged.
- Counters:
  - ack_cntX increments by 1 on each clk edge where mx.ack (as delivered) is high.
  - Modulo 2^CNT_WIDTH wrap, no saturation.
- Boundary conditions:
  - mx.cyc dropping in the same cycle as an ack: that ack counts, and release happens on that edge.
  - Both cyc rising together in IDLE: round-robin decides.
  - Master asserting stb without cyc: ignored.
  - rst_n low mid-burst: immediate return to reset values; the in-flight transfer is abandoned, with no ack delivered after reset assertion.
- Masters must drop cyc between logical transactions; a master holding cyc indefinitely starves the other (documented contract, not checked).

Decomposition:
- Package wb_arb_pkg:
  - arb_state_t enum {IDLE, GNT0, GNT1}.
  - Constants CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_END=3'b111.
- One sub-module, rr_arb2: 2-input round-robin decision (req[1:0], last, -> winner) holding the last-served pointer register.
- Mux and counters stay in wb_arbiter2.

Test Plan:
- Single write, m0 only: m0 write adr=0x10, dat=0xDEADBEEF, sel=1111 -> grant=01 one cycle after cyc; slave sees stb next cycle; m0.ack once; m1.ack stays 0; ack_cnt0=1.
- Simultaneous request after reset, FIRST_PRIO=0: m0 and m1 both raise cyc for single reads of 0x10 -> m0 served first, then grant goes directly to 10 with no IDLE cycle; m1 reads 0xDEADBEEF; ack_cnt0=1, ack_cnt1=1.
- Burst lock: m1 holds an 8-beat cti=010 read burst ending with cti=111 while m0 requests at beat 2 -> grant stays 10 until m1.cyc falls; m0 receives no ack before that; ack_cnt1=8; then m0 is granted.
- Round-robin fairness: both masters issue 4 back-to-back single-transfer cycles each -> grants alternate 01,10,01,10,...; final ack_cnt0=ack_cnt1=4.
- Async reset mid-burst: assert rst_n=0 at burst beat 3, between clock edges -> grant=00 and wb_s.cyc=0 immediately; counters=0; after release, a new m1 request is served normally.
- Counter wrap, CNT_WIDTH=4: 17 acks to m0 -> ack_cnt0 = 1.
